msi_snoop_responder: RTL

//  Snoop side of one MSI cache node: accepts bus messages from a remote requester and updates local line states.

---
 rtl/msi_snoop_responder_if.sv | 54 +++++
 rtl/msi_snoop_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/msi_snoop_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : msi_snoop_responder_if
//  Brief    : Snoop bus, local load/lookup and writeback signals of one node
//  Revision : 1.0 - initial release
// ============================================================================
interface msi_snoop_responder_if #(
  parameter int LINES  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
);
  localparam int IW = $clog2(LINES);

  logic              bus_valid;
  logic [1:0]        bus_msg;
  logic [IW-1:0]     bus_index;
  logic [TAG_W-1:0]  bus_tag;
  logic              bus_ready;

  logic              local_we;
  logic [IW-1:0]     local_index;
  logic [TAG_W-1:0]  local_wr_tag;
  logic [1:0]        local_wr_state;
  logic [DATA_W-1:0] local_wr_data;
  logic [1:0]        local_state;
  logic [TAG_W-1:0]  local_tag;

  logic              abort;
  logic              wb_valid;
  logic [IW-1:0]     wb_index;
  logic [TAG_W-1:0]  wb_tag;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic [7:0]        wb_count;

  modport slave (
    input  bus_valid, bus_msg, bus_index, bus_tag,
    output bus_ready,
    input  local_we, local_index, local_wr_tag, local_wr_state, local_wr_data,
    output local_state, local_tag,
    output abort, wb_valid, wb_index, wb_tag, wb_data, wb_count,
    input  wb_ready
  );

  modport master (
    output bus_valid, bus_msg, bus_index, bus_tag,
    input  bus_ready,
    output local_we, local_index, local_wr_tag, local_wr_state, local_wr_data,
    input  local_state, local_tag,
    input  abort, wb_valid, wb_index, wb_tag, wb_data, wb_count,
    output wb_ready
  );
endinterface
`default_nettype wire

// File: rtl/msi_snoop_responder.sv
`default_nettype none
// ============================================================================
//  Module   : msi_snoop_responder
//  Brief    : Snoop side of one MSI cache node with memory writeback port
//  Revision : 1.0 - initial release
// ============================================================================
module msi_snoop_responder #(
  parameter int LINES  = 4,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 8
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  msi_snoop_responder_if.slave  bus
);
  localparam int IW = $clog2(LINES);

  localparam logic [1:0] c_invalid    = 2'd0;
  localparam logic [1:0] c_shared     = 2'd1;
  localparam logic [1:0] c_modified   = 2'd2;
  localparam logic [1:0] c_read_miss  = 2'd0;
  localparam logic [1:0] c_reserved   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_WB    = 2'd2
  } fsm_t;

  fsm_t              r_fsm;
  fsm_t              w_fsm_next;

  logic [1:0]        r_state [LINES];
  logic [TAG_W-1:0]  r_tag   [LINES];
  logic [DATA_W-1:0] r_data  [LINES];

  logic [1:0]        r_msg;
  logic [IW-1:0]     r_idx;
  logic [TAG_W-1:0]  r_cap_tag;

  logic              r_abort;
  logic              r_wb_valid;
  logic [IW-1:0]     r_wb_index;
  logic [TAG_W-1:0]  r_wb_tag;
  logic [DATA_W-1:0] r_wb_data;
  logic [7:0]        r_wb_count;

  logic              w_accept;
  logic              w_load;
  logic              w_hit;
  logic              w_upd;
  logic [1:0]        w_upd_val;
  logic              w_wb_start;
  logic              w_wb_done;

  assign w_hit = (r_state[r_idx] != c_invalid) && (r_tag[r_idx] == r_cap_tag);

  always_comb begin
    w_fsm_next = r_fsm;
    w_accept   = 1'b0;
    w_load     = 1'b0;
    w_upd      = 1'b0;
    w_upd_val  = c_invalid;
    w_wb_start = 1'b0;
    w_wb_done  = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        w_load = bus.local_we;
        if (bus.bus_valid) begin
          w_accept   = 1'b1;
          w_fsm_next = S_CHECK;
        end
      end
      S_CHECK: begin
        w_fsm_next = S_IDLE;
        if (w_hit && r_msg != c_reserved) begin
          if (r_state[r_idx] == c_modified) begin
            w_wb_start = 1'b1;
            w_fsm_next = S_WB;
          end else if (r_msg != c_read_miss) begin
            w_upd     = 1'b1;
            w_upd_val = c_invalid;
          end
        end
      end
      S_WB: begin
        if (bus.wb_ready) begin
          w_wb_done  = 1'b1;
          w_upd      = 1'b1;
          w_upd_val  = (r_msg == c_read_miss) ? c_shared : c_invalid;
          w_fsm_next = S_IDLE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // Line storage: a local load in IDLE lands before CHECK reads the line.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < LINES; i++) begin
        r_state[i] <= c_invalid;
        r_tag[i]   <= '0;
        r_data[i]  <= '0;
      end
    end else begin
      if (w_load) begin
        r_state[bus.local_index] <= (bus.local_wr_state == 2'd3) ? c_invalid : bus.local_wr_state;
        r_tag[bus.local_index]   <= bus.local_wr_tag;
        r_data[bus.local_index]  <= bus.local_wr_data;
      end
      if (w_upd) begin
        r_state[r_idx] <= w_upd_val;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_msg      <= 2'd0;
      r_idx      <= '0;
      r_cap_tag  <= '0;
      r_abort    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_index <= '0;
      r_wb_tag   <= '0;
      r_wb_data  <= '0;
      r_wb_count <= 8'd0;
    end else begin
      if (w_accept) begin
        r_msg     <= bus.bus_msg;
        r_idx     <= bus.bus_index;
        r_cap_tag <= bus.bus_tag;
      end
      r_abort <= w_wb_start;
      if (w_wb_start) begin
        r_wb_valid <= 1'b1;
        r_wb_index <= r_idx;
        r_wb_tag   <= r_tag[r_idx];
        r_wb_data  <= r_data[r_idx];
      end else if (w_wb_done) begin
        r_wb_valid <= 1'b0;
        if (r_wb_count != 8'hFF) begin
          r_wb_count <= r_wb_count + 8'd1;
        end
      end
    end
  end

  assign bus.bus_ready   = (r_fsm == S_IDLE);
  assign bus.local_state = r_state[bus.local_index];
  assign bus.local_tag   = r_tag[bus.local_index];
  assign bus.abort       = r_abort;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_index    = r_wb_index;
  assign bus.wb_tag      = r_wb_tag;
  assign bus.wb_data     = r_wb_data;
  assign bus.wb_count    = r_wb_count;

endmodule
`default_nettype wire
